// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit SSD between two requesters; grant registers outputs and pulses ack next cycle.
// Each grant holds the display for DWELL_CYCLES; requests are ignored (not queued) while a dwell runs.
module ssd_display_arbiter #(
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        owner,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [3:0]  mode
);

    localparam int CW = $clog2(DWELL_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          arb;
    logic          any_req;
    logic          grant;

    assign arb     = (state == IDLE) || (cnt == CW'(DWELL_CYCLES - 1));
    assign any_req = req0 | req1;
    // On a tie the requester not currently shown wins, so ties alternate.
    assign grant   = (req0 & req1) ? ~owner : req1;
    assign busy    = (state == SHOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            owner  <= 1'b1;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            digit3 <= 4'h0;
            digit2 <= 4'h0;
            digit1 <= 4'h0;
            digit0 <= 4'h0;
            mode   <= 4'b0000;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (state == SHOW) begin
                cnt <= cnt + 1'b1;
            end
            if (arb) begin
                if (any_req) begin
                    state <= SHOW;
                    cnt   <= '0;
                    owner <= grant;
                    ack0  <= ~grant;
                    ack1  <= grant;
                    {digit3, digit2, digit1, digit0} <= grant ? data1 : data0;
                    mode  <= grant ? mask1 : mask0;
                end else begin
                    // Nothing pending: drop to IDLE but keep the last value on display.
                    state <= IDLE;
                    cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_display_arbiter.sv
module tb_ssd_display_arbiter;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic [3:0]  mask0, mask1;
    logic        ack0, ack1, busy, owner;
    logic [3:0]  digit3, digit2, digit1, digit0, mode;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          idx;
        logic [15:0] dat;
        logic [3:0]  msk;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    ssd_display_arbiter #(.DWELL_CYCLES(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .data0  (data0),
        .data1  (data1),
        .mask0  (mask0),
        .mask1  (mask1),
        .ack0   (ack0),
        .ack1   (ack1),
        .busy   (busy),
        .owner  (owner),
        .digit3 (digit3),
        .digit2 (digit2),
        .digit1 (digit1),
        .digit0 (digit0),
        .mode   (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every ack must match the oldest expected grant in cycle, owner, digits and mode.
    always @(negedge clk) begin
        exp_t e;
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            checks++;
            if (ack0 === 1'b1 && ack1 === 1'b1) begin
                errors++;
                $display("FAIL dual_ack ack0=%b ack1=%b required one-hot at cyc %0d", ack0, ack1, cyc);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack ack0=%b ack1=%b at cyc %0d, none expected", ack0, ack1, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (ack1 !== e.idx || ack0 !== !e.idx) begin
                    errors++;
                    $display("FAIL ack_idx ack0=%b ack1=%b required idx %0d", ack0, ack1, e.idx);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL ack_cycle got %0d required %0d", cyc, e.cyc);
                end
                checks++;
                if ({digit3, digit2, digit1, digit0} !== e.dat || mode !== e.msk || owner !== e.idx) begin
                    errors++;
                    $display("FAIL ack_display digits=%h mode=%b owner=%b required %h %b %b",
                             {digit3, digit2, digit1, digit0}, mode, owner, e.dat, e.msk, e.idx);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_busy got %b required 1", busy);
                end
            end
        end
    end

    task automatic wait_ack(input bit which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((which ? ack1 : ack0) === 1'b1) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        data0 = 16'h4321; mask0 = 4'b1010; data1 = 16'h0; mask1 = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0 || mode !== 4'b0000 || owner !== 1'b1 ||
            ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals digits=%h mode=%b owner=%b ack=%b%b busy=%b required 0000 0000 1 00 0",
                     {digit3, digit2, digit1, digit0}, mode, owner, ack0, ack1, busy);
        end
        rst = 1'b0;
        sb.push_back('{1'b0, 16'h4321, 4'b1010, cyc + 1});
        wait_ack(1'b0, seen);
        req0 = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_first_grant ack0 never seen, required within 40 cycles");
        end
        wait_idle(seen);
    endtask

    task automatic test_single;
        bit seen;
        int n;
        req1 = 1'b1; data1 = 16'hBEEF; mask1 = 4'b0111;
        sb.push_back('{1'b1, 16'hBEEF, 4'b0111, cyc + 1});
        wait_ack(1'b1, seen);
        req1 = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        checks++;
        if (n !== DW) begin
            errors++;
            $display("FAIL single_dwell busy cycles %0d required %0d", n, DW);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'hBEEF || mode !== 4'b0111 || owner !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_sticky digits=%h mode=%b owner=%b busy=%b required beef 0111 1 0",
                     {digit3, digit2, digit1, digit0}, mode, owner, busy);
        end
    endtask

    task automatic test_round_robin;
        bit seen;
        int n;
        int k;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'h1234; mask0 = 4'b1111; data1 = 16'hABCD; mask1 = 4'b1100;
        k = cyc + 1;
        for (int j = 0; j < 4; j++) begin
            if (j % 2 == 0) sb.push_back('{1'b0, 16'h1234, 4'b1111, k + j * DW});
            else            sb.push_back('{1'b1, 16'hABCD, 4'b1100, k + j * DW});
        end
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) n++;
            if (n == 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_ack_count got %0d required 4", n);
        end
        wait_idle(seen);
    endtask

    task automatic test_show_request;
        bit seen;
        int g;
        req0 = 1'b1; data0 = 16'h5A5A; mask0 = 4'b1111;
        sb.push_back('{1'b0, 16'h5A5A, 4'b1111, cyc + 1});
        wait_ack(1'b0, seen);
        g = cyc;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        req1 = 1'b1; data1 = 16'hC0DE; mask1 = 4'b1110;
        sb.push_back('{1'b1, 16'hC0DE, 4'b1110, g + DW});
        @(negedge clk);
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h5A5A || owner !== 1'b0) begin
            errors++;
            $display("FAIL show_ignore digits=%h owner=%b required 5a5a 0",
                     {digit3, digit2, digit1, digit0}, owner);
        end
        wait_ack(1'b1, seen);
        req1 = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL show_req_ack ack1 never seen, required at cyc %0d", g + DW);
        end
        wait_idle(seen);
    endtask

    task automatic test_withdraw;
        bit seen;
        int n1;
        req0 = 1'b1; data0 = 16'h0F0F; mask0 = 4'b0011;
        sb.push_back('{1'b0, 16'h0F0F, 4'b0011, cyc + 1});
        wait_ack(1'b0, seen);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        req1 = 1'b1; data1 = 16'hDEAD; mask1 = 4'b1111;
        repeat (2) @(negedge clk);
        req1 = 1'b0;
        n1 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) n1++;
        end
        checks++;
        if (n1 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw ack1 count %0d busy=%b required 0 0", n1, busy);
        end
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0F0F || mode !== 4'b0011 || owner !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_display digits=%h mode=%b owner=%b required 0f0f 0011 0",
                     {digit3, digit2, digit1, digit0}, mode, owner);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        req0 = 1'b1; data0 = 16'h9876; mask0 = 4'b1001;
        sb.push_back('{1'b0, 16'h9876, 4'b1001, cyc + 1});
        wait_ack(1'b0, seen);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; req0 = 1'b1; data0 = 16'h1111; mask0 = 4'b0110;
        @(negedge clk);
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0 || mode !== 4'b0000 || busy !== 1'b0 ||
            ack0 !== 1'b0 || ack1 !== 1'b0 || owner !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid digits=%h mode=%b busy=%b ack=%b%b owner=%b required 0000 0000 0 00 1",
                     {digit3, digit2, digit1, digit0}, mode, busy, ack0, ack1, owner);
        end
        rst = 1'b0;
        sb.push_back('{1'b0, 16'h1111, 4'b0110, cyc + 1});
        wait_ack(1'b0, seen);
        req0 = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_regrant ack0 never seen after reset release");
        end
        wait_idle(seen);
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_show_request;
        test_withdraw;
        test_reset_mid;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain %0d expected grants never acked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ssd_display_arbiter.md
# ssd_display_arbiter

Shares one 4-digit seven-segment display between two independent requesters, such as two arithmetic test units, each wanting to show a 16-bit value. It sits directly in front of the 4-digit SSD controller and drives that controller's `digit3..digit0` and `mode` inputs. Requests are granted round-robin, and each granted value is held on the display for a fixed dwell time. When no request is pending, the last value shown stays on the display.

## Interface
- `DWELL_CYCLES`, default 100000000 — clock cycles a granted value is guaranteed on display (1 s at 10 ns); legal range ≥ 2.
- `clk` in 1 — system clock; single clock domain.
- `rst` in 1 — synchronous, active-high reset.
- `req0`, `req1` in 1 — display request; held high until the matching ack.
- `data0`, `data1` in 16 — value to show; nibble [15:12] → `digit3` … [3:0] → `digit0`; sampled on the granting edge only.
- `mask0`, `mask1` in 4 — per-digit enable forwarded to `mode`; bit i enables digit i.
- `ack0`, `ack1` out 1 — one-cycle pulse in the first cycle the granted value is displayed.
- `busy` out 1 — high while in SHOW (dwell running).
- `owner` out 1 — index of the requester whose value is on the display.
- `digit3`, `digit2`, `digit1`, `digit0` out 4 each — registered digits to the SSD controller.
- `mode` out 4 — registered digit enables to the SSD controller.

## Operation
- Two states: IDLE and SHOW.
- **Arbitration** is evaluated on any edge where the state is IDLE, or where the state is SHOW and the dwell counter is at `DWELL_CYCLES-1`:
  - Only one of `req0`/`req1` high → grant that requester.
  - Both high → grant the requester that is not the current `owner` (round-robin).
  - Neither high → the state becomes or remains IDLE. `digit*`, `mode` and `owner` hold their values (sticky display).
- **Grant edge:**
  - `digit3..0` ← granted `data`; `mode` ← granted `mask`; `owner` ← granted index.
  - Granted `ack` = 1 for the next cycle; dwell counter ← 0; state ← SHOW.
- **SHOW:**
  - Counter increments by 1 per edge; width `$clog2(DWELL_CYCLES)`.
  - All `req` inputs are ignored until expiry. There is no preemption and no refresh by the current owner.
- A requester drops `req` in response to `ack`. A `req` still high at the next arbitration point is treated as a new request.
- Deasserting `req` before it is granted withdraws the request; no ack is produced.
- Inputs are used as given, with no width conversion. Digits are passed through unmodified; the encoding is done downstream.

## Timing
- **Reset values:** state IDLE, counter 0, `digit3..0` = 0, `mode` = 4'b0000 (display blank), `owner` = 1 (so `req0` wins the first tie), `ack0` = `ack1` = 0, `busy` = 0.
- `rst` high on any edge overrides everything, including mid-dwell and the grant edge; no ack is issued in that cycle.
- **Grant latency:** request sampled high at edge k in IDLE → outputs updated and ack high in cycle k..k+1.
- **Dwell:** SHOW lasts exactly `DWELL_CYCLES` cycles. With a request pending at expiry, the next grant takes effect at edge k+`DWELL_CYCLES`. Handover is back-to-back with no IDLE cycle and no blank cycle.
- At most one `ack` is high in any cycle. `ack` is never high in two consecutive cycles for the same requester unless `DWELL_CYCLES` = 1, which is illegal.
- `busy` = 1 exactly while the state is SHOW, including the ack cycle.
- Ties at expiry alternate strictly. A requester holding `req` continuously can therefore never starve the other.

## Test plan
`DWELL_CYCLES` = 8 for all scenarios.

- **Reset:** `rst` for 2 cycles with `req0` = 1 → all outputs at reset values; first grant edge is the edge after `rst` falls; `ack0` pulse, `digit3..0` = 4,3,2,1 for `data0` = 16'h4321, `mode` = `mask0`.
- **Single request and dwell:** `req1` with `data1` = 16'hBEEF, `mask1` = 4'b0111, then dropped on ack → `busy` high exactly 8 cycles; after that, IDLE with digits B,E,E,F and `mode` 4'b0111 still held; `owner` = 1.
- **Tie and round-robin:** both `req` held high continuously after reset → acks alternate `ack0`, `ack1`, `ack0` … spaced exactly 8 cycles apart, with no gap cycle between them.
- **Request during SHOW:** `req1` raised 3 cycles into `owner` 0's dwell → ignored until expiry; `ack1` at exactly the grant edge + 8; digits switch in that same cycle.
- **Withdrawn request:** `req1` pulsed for 2 cycles mid-dwell and dropped before expiry → no `ack1`; state returns to IDLE; display unchanged.
- **Reset mid-dwell:** `rst` asserted at dwell count 5 → next cycle blank (`mode` 0, digits 0), `busy` 0, no ack; a pending `req0` is granted on the first edge after `rst` deasserts.
